// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with valid/ready handshakes on both sides.
// Define SIPO_PARITY_EN to append an even-parity bit per frame and expose o_perr.
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    input  logic             o_ready,
`ifdef SIPO_PARITY_EN
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       o_perr
`else
    output logic [$clog2(WIDTH)-1:0]   bit_cnt
`endif
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CW   = $clog2(FRAME);
    // Shift register holds every frame bit except the last, which comes from i.
    localparam int SR_W = FRAME - 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [SR_W-1:0]  r_sr;
    logic [SR_W-1:0]  w_sr_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_o;
    logic             r_valid;
    logic [WIDTH-1:0] w_word;
    logic             w_last;
    logic             w_accept;
    logic             w_done;
    logic             w_shift_en;

    assign w_last   = (r_cnt == LAST);
    // i_ready is combinational from o_ready: the final bit may enter on the
    // same edge the held word is consumed.
    assign i_ready  = ~w_last | ~r_valid | o_ready;
    assign w_accept = i_valid & i_ready;
    assign w_done   = w_accept & w_last;

`ifdef SIPO_PARITY_EN
    assign w_shift_en = w_accept & ~w_last;
    assign w_word     = r_sr;
`else
    assign w_shift_en = w_accept;
    assign w_word     = MSB_FIRST ? {r_sr, i} : {i, r_sr};
`endif

    generate
        if (SR_W == 1) begin : g_sr1
            assign w_sr_next = i;
        end else if (MSB_FIRST) begin : g_msb
            assign w_sr_next = {r_sr[SR_W-2:0], i};
        end else begin : g_lsb
            assign w_sr_next = {i, r_sr[SR_W-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr <= '0;
        end else if (w_shift_en) begin
            r_sr <= w_sr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o <= '0;
        end else if (w_done) begin
            r_o <= w_word;
        end
    end

    // A completion on the consume edge keeps valid high: no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
        end else if (w_done) begin
            r_valid <= 1'b1;
        end else if (o_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef SIPO_PARITY_EN
    logic r_perr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perr <= 1'b0;
        end else if (w_done) begin
            r_perr <= (^r_sr) ^ i;
        end
    end

    assign o_perr = r_perr;
`endif

    assign o       = r_o;
    assign o_valid = r_valid;
    assign bit_cnt = r_cnt;

endmodule

// File: tb/tb_sipo_deser.sv
// Randomised and directed bench for sipo_deser, both bit orders side by side.
// Reference model keeps received bits in a queue and assembles words from it.
module tb_sipo_deser;

    localparam int W = 4;
`ifdef SIPO_PARITY_EN
    localparam int FR = W + 1;
`else
    localparam int FR = W;
`endif
    localparam int CW = $clog2(FR);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_bit = 1'b0;
    logic          i_valid = 1'b0;
    logic          o_ready = 1'b0;
    logic          rdy0, rdy1;
    logic [W-1:0]  o0, o1;
    logic          ov0, ov1;
    logic [CW-1:0] bc0, bc1;
`ifdef SIPO_PARITY_EN
    logic          perr0, perr1;
`endif

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .i(i_bit), .i_valid(i_valid),
        .i_ready(rdy0), .o(o0), .o_valid(ov0), .o_ready(o_ready),
`ifdef SIPO_PARITY_EN
        .bit_cnt(bc0), .o_perr(perr0)
`else
        .bit_cnt(bc0)
`endif
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .i(i_bit), .i_valid(i_valid),
        .i_ready(rdy1), .o(o1), .o_valid(ov1), .o_ready(o_ready),
`ifdef SIPO_PARITY_EN
        .bit_cnt(bc1), .o_perr(perr1)
`else
        .bit_cnt(bc1)
`endif
    );

    int checks = 0;
    int errors = 0;

    bit           q[$];
    bit           m_valid;
    logic [W-1:0] m_lsb, m_msb;
    bit           m_perr;
    bit           exp_rdy;
    logic         obs_rdy0, obs_rdy1;

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_lsb   = '0;
        m_msb   = '0;
        m_perr  = 1'b0;
    endtask

    // One clock cycle: drive at negedge, sample i_ready before the edge,
    // advance the model at the edge, return at the next negedge.
    task automatic step(input bit v, input bit b, input bit r);
        bit acc;
        bit done;
        i_valid = v;
        i_bit   = b;
        o_ready = r;
        #1;
        obs_rdy0 = rdy0;
        obs_rdy1 = rdy1;
        exp_rdy  = (q.size() != FR - 1) || !m_valid || r;
        acc      = v && exp_rdy;
        done     = 1'b0;
        @(posedge clk);
        if (acc) begin
            q.push_back(b);
            if (q.size() == FR) done = 1'b1;
        end
        if (done) begin
            for (int k = 0; k < W; k++) begin
                m_lsb[k]     = q[k];
                m_msb[W-1-k] = q[k];
            end
            m_perr = 1'b0;
            foreach (q[k]) m_perr ^= q[k];
            m_valid = 1'b1;
            q.delete();
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send_frame(input bit f[W], input bit r);
        bit p;
        p = 1'b0;
        for (int k = 0; k < W; k++) begin
            step(1'b1, f[k], r);
            p ^= f[k];
        end
`ifdef SIPO_PARITY_EN
        step(1'b1, p, r);
`endif
    endtask

    task automatic test_reset();
        #1;
        rst     = 1'b1;
        i_bit   = 1'($urandom);
        i_valid = 1'($urandom);
        o_ready = 1'($urandom);
        #1;
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL rst_ov got %b exp 0", ov0); end
        checks++; if (o0 !== '0) begin errors++; $display("FAIL rst_o got %h exp 0", o0); end
        checks++; if (bc0 !== '0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bc0); end
        @(posedge clk);
        #1;
        checks++; if (ov1 !== 1'b0 || o1 !== '0) begin errors++; $display("FAIL rst_hold got %b/%h exp 0/0", ov1, o1); end
        rst     = 1'b0;
        i_valid = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rst_rdy got %b exp 1", rdy0); end
    endtask

    task automatic test_stream();
        send_frame('{1'b1, 1'b0, 1'b1, 1'b1}, 1'b1);
        checks++; if (ov0 !== 1'b1) begin errors++; $display("FAIL stream_ov got %b exp 1", ov0); end
        checks++; if (o0 !== 4'b1101) begin errors++; $display("FAIL stream_lsb got %b exp 1101", o0); end
        checks++; if (o1 !== 4'b1011) begin errors++; $display("FAIL stream_msb got %b exp 1011", o1); end
        checks++; if (bc0 !== '0) begin errors++; $display("FAIL stream_cnt got %0d exp 0", bc0); end
        step(1'b0, 1'b0, 1'b1);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL stream_drop got %b exp 0", ov0); end
    endtask

    task automatic test_backpressure();
        bit seq[$];
        for (int k = 0; k < W; k++) seq.push_back(1'b1);
        if (FR > W) seq.push_back(1'b0);
        for (int k = 0; k < FR; k++) seq.push_back(1'b0);
        for (int k = 0; k < 2 * FR - 1; k++) begin
            step(1'b1, seq[k], 1'b0);
            if (k == FR - 1) begin
                checks++; if (ov0 !== 1'b1 || o0 !== 4'b1111) begin errors++; $display("FAIL bp_first got %b/%b exp 1/1111", ov0, o0); end
            end
        end
        for (int n = 0; n < 2; n++) begin
            step(1'b1, seq[2*FR-1], 1'b0);
            checks++; if (obs_rdy0 !== 1'b0 || obs_rdy1 !== 1'b0) begin errors++; $display("FAIL bp_stall got %b%b exp 00", obs_rdy0, obs_rdy1); end
            checks++; if (o0 !== 4'b1111 || ov0 !== 1'b1) begin errors++; $display("FAIL bp_hold got %b/%b exp 1111/1", o0, ov0); end
            checks++; if (bc0 !== CW'(FR - 1)) begin errors++; $display("FAIL bp_cnt got %0d exp %0d", bc0, FR - 1); end
        end
        step(1'b1, seq[2*FR-1], 1'b1);
        checks++; if (obs_rdy0 !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", obs_rdy0); end
        checks++; if (ov0 !== 1'b1 || o0 !== 4'b0000 || o1 !== 4'b0000) begin errors++; $display("FAIL bp_next got %b/%b/%b exp 1/0000/0000", ov0, o0, o1); end
        step(1'b0, 1'b0, 1'b1);
        checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", ov0); end
    endtask

    task automatic test_gapped();
        int nb;
        nb = 0;
        for (int c = 0; c < 2 * FR - 1; c++) begin
            if (c % 2 == 0) begin
                step(1'b1, (nb < W) ? 1'(nb % 2) : 1'b0, 1'b1);
                nb++;
            end else begin
                step(1'b0, 1'($urandom), 1'b1);
            end
            if (c == 2 * FR - 3) begin
                checks++; if (ov0 !== 1'b0) begin errors++; $display("FAIL gap_early got %b exp 0", ov0); end
            end
        end
        checks++; if (ov0 !== 1'b1 || o0 !== 4'b1010) begin errors++; $display("FAIL gap_lsb got %b/%b exp 1/1010", ov0, o0); end
        checks++; if (o1 !== 4'b0101) begin errors++; $display("FAIL gap_msb got %b exp 0101", o1); end
        step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        bit f[W];
        foreach (f[k]) f[k] = 1'($urandom);
        send_frame(f, 1'b0);
        step(1'b1, 1'($urandom), 1'b0);
        step(1'b1, 1'($urandom), 1'b0);
        checks++; if (bc0 !== CW'(2) || ov0 !== 1'b1) begin errors++; $display("FAIL ar_pre got %0d/%b exp 2/1", bc0, ov0); end
        i_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++; if (ov0 !== 1'b0 || ov1 !== 1'b0) begin errors++; $display("FAIL ar_ov got %b%b exp 00", ov0, ov1); end
        checks++; if (bc0 !== '0 || o0 !== '0) begin errors++; $display("FAIL ar_clr got %0d/%h exp 0/0", bc0, o0); end
        #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        foreach (f[k]) f[k] = 1'($urandom);
        send_frame(f, 1'b1);
        checks++; if (ov0 !== 1'b1 || o0 !== m_lsb || o1 !== m_msb) begin errors++; $display("FAIL ar_word got %b/%b/%b exp 1/%b/%b", ov0, o0, o1, m_lsb, m_msb); end
        step(1'b0, 1'b0, 1'b1);
    endtask

`ifdef SIPO_PARITY_EN
    task automatic test_parity();
        bit d[W] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < W; k++) step(1'b1, d[k], 1'b1);
        step(1'b1, 1'b1, 1'b1);
        checks++; if (ov0 !== 1'b1 || perr0 !== 1'b0) begin errors++; $display("FAIL par_good got %b/%b exp 1/0", ov0, perr0); end
        for (int k = 0; k < W; k++) step(1'b1, d[k], 1'b1);
        step(1'b1, 1'b0, 1'b1);
        checks++; if (perr0 !== 1'b1 || perr1 !== 1'b1) begin errors++; $display("FAIL par_bad got %b%b exp 11", perr0, perr1); end
        checks++; if (o0 !== 4'b1101) begin errors++; $display("FAIL par_word got %b exp 1101", o0); end
        step(1'b0, 1'b0, 1'b1);
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) != 0);
            checks++; if (obs_rdy0 !== exp_rdy || obs_rdy1 !== exp_rdy) begin errors++; $display("FAIL rnd_rdy cyc %0d got %b%b exp %b", n, obs_rdy0, obs_rdy1, exp_rdy); end
            checks++; if (ov0 !== m_valid || ov1 !== m_valid) begin errors++; $display("FAIL rnd_ov cyc %0d got %b%b exp %b", n, ov0, ov1, m_valid); end
            checks++; if (bc0 !== CW'(q.size()) || bc1 !== CW'(q.size())) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", n, bc0, q.size()); end
            checks++; if (o0 !== m_lsb) begin errors++; $display("FAIL rnd_lsb cyc %0d got %b exp %b", n, o0, m_lsb); end
            checks++; if (o1 !== m_msb) begin errors++; $display("FAIL rnd_msb cyc %0d got %b exp %b", n, o1, m_msb); end
`ifdef SIPO_PARITY_EN
            checks++; if (perr0 !== m_perr) begin errors++; $display("FAIL rnd_perr cyc %0d got %b exp %b", n, perr0, m_perr); end
`endif
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_gapped();
        test_async_reset();
`ifdef SIPO_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
